// File: rtl/text_plane_buffer.sv
// -----------------------------------------------------------------------------
// text_plane_buffer
//
// Character plane for the text display path: ROWS x COLS cells of CW-bit
// character codes. A terminal-style command stream (PUT, NEWLINE, BACKSPACE,
// CLEAR) writes through an internal cursor. The display scanner reads any
// cell through a registered, one-cycle-latency read port. A sequential engine
// blanks the plane (FILL) and, when enabled, scrolls it up one row (SCROLL).
//
// Build option:
//   TEXT_PLANE_SCROLL_EN  defined   -> advancing past the last row scrolls
//                                      the plane up and keeps the cursor on
//                                      the last row.
//                         undefined -> advancing past the last row wraps the
//                                      cursor to row 0; no scroll hardware.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset (restarts a full clear)
//   cmd       in   0 PUT, 1 NEWLINE, 2 BACKSPACE, 3 CLEAR
//   din       in   character for PUT (ERASE is stored as BLANK)
//   in_valid  in   command present
//   in_ready  out  command accepted on this edge when in_valid is high
//   rd_row    in   display read row
//   rd_col    in   display read column
//   rd_data   out  registered cell contents (BLANK when address out of range)
//   cur_row   out  cursor row
//   cur_col   out  cursor column
//   busy      out  clear/scroll engine active
// -----------------------------------------------------------------------------
module text_plane_buffer #(
  parameter int unsigned   ROWS  = 7,
  parameter int unsigned   COLS  = 20,
  parameter int unsigned   CW    = 8,
  parameter logic [CW-1:0] BLANK = CW'(129),
  parameter logic [CW-1:0] ERASE = CW'(8'hFF),
  localparam int unsigned  RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned  CLW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     cmd,
  input  logic [CW-1:0]  din,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [RW-1:0]  rd_row,
  input  logic [CLW-1:0] rd_col,
  output logic [CW-1:0]  rd_data,
  output logic [RW-1:0]  cur_row,
  output logic [CLW-1:0] cur_col,
  output logic           busy
);

  localparam int unsigned CELLS = ROWS * COLS;
  // Wide enough to hold CELLS itself so no linear index ever truncates.
  localparam int unsigned IW    = $clog2(CELLS + 1);

  localparam logic [IW-1:0]  IDX_LAST = IW'(CELLS - 1);
  localparam logic [IW-1:0]  IDX_COLS = IW'(COLS);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
  localparam logic [RW:0]    ROWS_EXT = (RW + 1)'(ROWS);
  localparam logic [CLW:0]   COLS_EXT = (CLW + 1)'(COLS);
`ifdef TEXT_PLANE_SCROLL_EN
  localparam logic [IW-1:0]  IDX_SCROLL_LAST = IW'((ROWS - 1) * COLS - 1);
  localparam logic [IW-1:0]  IDX_LAST_ROW    = IW'((ROWS - 1) * COLS);
`endif

  localparam logic [1:0] CMD_PUT       = 2'd0;
  localparam logic [1:0] CMD_NEWLINE   = 2'd1;
  localparam logic [1:0] CMD_BACKSPACE = 2'd2;
  localparam logic [1:0] CMD_CLEAR     = 2'd3;

`ifdef TEXT_PLANE_SCROLL_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SCROLL = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1
  } state_e;
`endif

  // Row-major linear cell index at full index width.
  function automatic logic [IW-1:0] lin_idx(input logic [RW-1:0] row,
                                            input logic [CLW-1:0] col);
    return (IW'(row) * IDX_COLS) + IW'(col);
  endfunction

  logic [CW-1:0]  mem_q [CELLS];

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic [CW-1:0]  rd_data_q;

  logic           accept;
  logic           adv_row;
  logic [IW-1:0]  cur_idx;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [CW-1:0]  wr_data;
  logic           rd_ok;
  logic [IW-1:0]  rd_idx;

  assign in_ready = (state_q == S_IDLE) && reset;
  assign busy     = (state_q != S_IDLE);
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign rd_data  = rd_data_q;

  assign accept  = in_valid && in_ready;
  assign cur_idx = lin_idx(row_q, col_q);
  assign rd_ok   = ({1'b0, rd_row} < ROWS_EXT) && ({1'b0, rd_col} < COLS_EXT);
  assign rd_idx  = rd_ok ? lin_idx(rd_row, rd_col) : '0;

  // Command decode, cursor movement, engine sequencing and the single write port.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    adv_row = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_data = BLANK;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_PUT: begin
              wr_en   = 1'b1;
              wr_data = (din == ERASE) ? BLANK : din;
              if (col_q == COL_LAST) begin
                col_d   = '0;
                adv_row = 1'b1;
              end else begin
                col_d = col_q + CLW'(1);
              end
            end
            CMD_NEWLINE: begin
              col_d   = '0;
              adv_row = 1'b1;
            end
            CMD_BACKSPACE: begin
              // The new position is always the linear predecessor, whether
              // stepping left in the row or wrapping to the previous row end.
              if (col_q != '0) begin
                col_d  = col_q - CLW'(1);
                wr_en  = 1'b1;
                wr_idx = cur_idx - IW'(1);
              end else if (row_q != '0) begin
                row_d  = row_q - RW'(1);
                col_d  = COL_LAST;
                wr_en  = 1'b1;
                wr_idx = cur_idx - IW'(1);
              end else begin
                // Home position: nothing to erase, cursor stays.
                row_d = row_q;
              end
            end
            CMD_CLEAR: begin
              row_d   = '0;
              col_d   = '0;
              state_d = S_FILL;
              idx_d   = '0;
            end
            default: begin
              row_d = row_q;
            end
          endcase
          if (adv_row) begin
            if (row_q != ROW_LAST) begin
              row_d = row_q + RW'(1);
            end else begin
`ifdef TEXT_PLANE_SCROLL_EN
              row_d   = ROW_LAST;
              state_d = S_SCROLL;
              idx_d   = '0;
`else
              row_d   = '0;
`endif
            end
          end else begin
            adv_row = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        wr_en  = 1'b1;
        wr_idx = idx_q;
        if (idx_q == IDX_LAST) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef TEXT_PLANE_SCROLL_EN
      S_SCROLL: begin
        // Copy the cell one row below into the current cell; the last row
        // is left for the FILL pass that follows.
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = mem_q[idx_q + IDX_COLS];
        if (idx_q == IDX_SCROLL_LAST) begin
          state_d = S_FILL;
          idx_d   = IDX_LAST_ROW;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`endif
      default: begin
        // Unreachable encoding: recover by re-clearing the plane.
        state_d = S_FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Engine state, engine index and cursor registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Cell storage; no reset so it maps onto RAM, the FILL pass initialises it.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Registered display read port; sees pre-write contents on a same-cell hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= BLANK;
    end else if (rd_ok) begin
      rd_data_q <= mem_q[rd_idx];
    end else begin
      rd_data_q <= BLANK;
    end
  end

endmodule
